noc2_vr_packet_arb: RTL

- Packet-level round-robin arbiter that shares one NoC2 val/rdy request channel (the input of noc_axi4_bridge) between NUM_SRC requesters, e.g. several credit_to_valrdy-converted chip ports.
- Sits between the credit-to-val/rdy converters and the bridge's src_bridge_vr_noc2_* inputs.
- Locks the grant for a whole OpenPiton packet: one header flit plus the number of payload flits given in the header MSG_LENGTH field.
- The bridge therefore never sees interleaved flits from different sources.

---
 rtl/noc2_vr_packet_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/noc2_vr_packet_arb.sv
// Packet-level round-robin arbiter sharing one NoC2 val/rdy channel between NUM_SRC requesters.
// The grant is held from the header flit until the last payload flit, so flits never interleave.
module noc2_vr_packet_arb #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_HI     = 29,
  parameter int LEN_LO     = 22
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              src_val,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_dat,
  output logic [NUM_SRC-1:0]              src_rdy,
  output logic                            dst_val,
  output logic [DATA_WIDTH-1:0]           dst_dat,
  input  logic                            dst_rdy,
  output logic [NUM_SRC-1:0]              grant_o,
  output logic                            busy_o,
  output logic [31:0]                     pkt_cnt_o
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LW = LEN_HI - LEN_LO + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic [IW-1:0]           rr_q, rr_d;
  logic [LW-1:0]           rem_q, rem_d;
  logic [31:0]             cnt_q, cnt_d;

  logic                    busy;
  logic                    sel_val;
  logic [DATA_WIDTH-1:0]   sel_dat;
  logic [IW-1:0]           next_ptr;
  logic [NUM_SRC-1:0]      win;
  logic                    xfer;
  logic                    pkt_done;
  logic [LW-1:0]           hdr_len;

  // Mux of the granted source; next_ptr is the index just after the owner.
  always_comb begin
    sel_val  = 1'b0;
    sel_dat  = '0;
    next_ptr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        sel_val  = src_val[i];
        sel_dat  = src_dat[i*DATA_WIDTH +: DATA_WIDTH];
        next_ptr = IW'((i + 1) % NUM_SRC);
      end
    end
  end

  // Round-robin search starting at rr_q; the first requester found wins.
  always_comb begin
    logic found;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!found && src_val[j] && (j == ((int'(rr_q) + k) % NUM_SRC))) begin
          win[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign dst_val = busy & sel_val;
  assign dst_dat = busy ? sel_dat : '0;
  assign src_rdy = busy ? (grant_q & {NUM_SRC{dst_rdy}}) : '0;
  assign xfer    = dst_val & dst_rdy;
  assign hdr_len = sel_dat[LEN_HI:LEN_LO];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    pkt_done = 1'b0;
    case (state_q)
      IDLE: begin
        // Arbitration costs one bubble cycle: nothing is passed through here.
        if (|src_val) begin
          grant_d = win;
          state_d = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          if (hdr_len == '0) begin
            pkt_done = 1'b1;
          end else begin
            rem_d   = hdr_len;
            state_d = PAY;
          end
        end
      end
      PAY: begin
        if (xfer) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LW'(1)) pkt_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (pkt_done) begin
      state_d = IDLE;
      grant_d = '0;
      rr_d    = next_ptr;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy;
  assign pkt_cnt_o = cnt_q;

endmodule
